// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 push-button matrix one row at a time with an
// active-low row select, debounces whole 16-key frames, and reports single-shot
// key events (no roll-over) plus held / multi-key status.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 1,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic        key_multi,
  output logic [15:0] key_state
);

  typedef enum logic [1:0] {
    DRIVE,
    WAIT,
    SAMPLE,
    FRAME_END
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STABLE_GOAL = 4'(DEBOUNCE_FRAMES);

  state_t      state;
  logic [1:0]  row_idx;
  logic [3:0]  settle_cnt;
  logic [15:0] snapshot;
  logic [15:0] prev_snapshot;
  logic [3:0]  stable_cnt;

  logic [3:0]  next_stable_cnt;
  logic [15:0] next_key_state;

  // Index of the lowest pressed key; only consulted when exactly one bit is set.
  function automatic logic [3:0] first_set(input logic [15:0] v);
    first_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) first_set = i[3:0];
    end
  endfunction

  // Debounce decision for the frame that has just been fully sampled.
  always_comb begin
    next_stable_cnt = 4'd1;
    next_key_state  = key_state;
    if (snapshot == prev_snapshot) begin
      next_stable_cnt = (stable_cnt >= STABLE_GOAL) ? STABLE_GOAL : stable_cnt + 4'd1;
    end
    if (next_stable_cnt == STABLE_GOAL) begin
      next_key_state = snapshot;
    end
  end

  // Row scan sequencer with frame-end debounce and single-shot event generation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= DRIVE;
      row_idx       <= 2'd0;
      settle_cnt    <= 4'd0;
      snapshot      <= 16'h0000;
      prev_snapshot <= 16'h0000;
      stable_cnt    <= 4'd0;
      row_out       <= 4'hF;
      key_code      <= 4'd0;
      key_valid     <= 1'b0;
      key_held      <= 1'b0;
      key_multi     <= 1'b0;
      key_state     <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      case (state)
        DRIVE: begin
          row_out <= ~(4'b0001 << row_idx);
          state   <= WAIT;
        end
        WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          snapshot[{row_idx, 2'b00} +: 4] <= ~col_in;
          if (row_idx == 2'd3) begin
            state <= FRAME_END;
          end else begin
            row_idx <= row_idx + 2'd1;
            state   <= DRIVE;
          end
        end
        FRAME_END: begin
          row_out       <= 4'hF;
          row_idx       <= 2'd0;
          prev_snapshot <= snapshot;
          stable_cnt    <= next_stable_cnt;
          key_state     <= next_key_state;
          key_held      <= ($countones(next_key_state) == 1);
          key_multi     <= ($countones(next_key_state) >= 2);
          if (($countones(next_key_state) == 1) && ($countones(key_state) == 0)) begin
            key_valid <= 1'b1;
            key_code  <= first_set(next_key_state);
          end
          state <= DRIVE;
        end
        default: begin
          state <= DRIVE;
        end
      endcase
    end
  end

endmodule
